// File: rtl/sseg_scan_mux.sv
// Time-multiplexed hex seven-segment scanner with refresh prescaler, per-digit enables and anti-ghost blanking.
// Optional decimal-point path is enabled by defining SSEG_DP_EN.
module sseg_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     digit_en,
`ifdef SSEG_DP_EN
  input  logic [NUM_DIGITS-1:0]     dp_in,
  output logic                      dp_n,
`endif
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MAX    = IW'(NUM_DIGITS - 1);

  typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} state_t;

  // Active-low cathode pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  state_t                state_q, state_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  lit_s;
  logic [3:0]            nib_s;

  assign nib_s = digits[{idx_q, 2'b00} +: 4];
  assign lit_s = (state_q == DRIVE) && digit_en[idx_q];

  // Next-state: prescaler, digit index, blank/drive phase and the output pattern.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    state_d = state_q;
    an_d    = {NUM_DIGITS{1'b1}};
    seg_d   = 7'h7F;

    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // State tracks presc: DRIVE exactly while presc >= BLANK_CYCLES.
    case (state_q)
      BLANK:   state_d = (presc_q == BLANK_LAST) ? DRIVE : BLANK;
      DRIVE:   state_d = (presc_q == PRESC_MAX) ? BLANK : DRIVE;
      default: state_d = BLANK;
    endcase

    if (lit_s) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = hex_to_seg(nib_s);
    end else begin
      an_d  = {NUM_DIGITS{1'b1}};
      seg_d = 7'h7F;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      state_q <= BLANK;
      an_q    <= {NUM_DIGITS{1'b1}};
      seg_q   <= 7'h7F;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

`ifdef SSEG_DP_EN
  logic dp_n_q, dp_n_d;

  always_comb begin
    if (lit_s) begin
      dp_n_d = ~dp_in[idx_q];
    end else begin
      dp_n_d = 1'b1;
    end
  end

  // Decimal point registered alongside the segments.
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_n_q <= 1'b1;
    end else begin
      dp_n_q <= dp_n_d;
    end
  end

  assign dp_n = dp_n_q;
`endif

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Randomized self-checking bench for sseg_scan_mux (NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2).
// The reference computes the expected display from the cycle count since reset release.
module tb_sseg_scan_mux;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [4*N-1:0] digits;
  logic [N-1:0] digit_en;
  logic [N-1:0] an;
  logic [6:0]   seg;
`ifdef SSEG_DP_EN
  logic [N-1:0] dp_in;
  logic         dp_n;
`endif

  int checks = 0;
  int errors = 0;
  int n_edges = 0;

  logic [6:0] hex_tbl [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  sseg_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk      (clk),
    .reset    (reset),
    .digits   (digits),
    .digit_en (digit_en),
`ifdef SSEG_DP_EN
    .dp_in    (dp_in),
    .dp_n     (dp_n),
`endif
    .an       (an),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (edge %0d)", tag, obs, exp, n_edges);
    end
  endtask

  // One clock edge: advance the reference, then compare outputs 1 time unit later.
  task automatic step();
    int p, slot, phase;
    bit lit;
    logic [N-1:0] exp_an;
    logic [6:0]   exp_seg;
    logic [3:0]   nib;
    logic         exp_dp;
    @(posedge clk);
    if (reset) n_edges = 0;
    else n_edges++;
    // The output seen after edge n reflects scan position n-1 (registered).
    p = n_edges - 1;
    lit = 1'b0;
    slot = 0;
    if (p >= 0) begin
      phase = p % R;
      slot  = (p / R) % N;
      lit   = (phase >= B) && digit_en[slot];
    end
    nib     = digits[slot*4 +: 4];
    exp_an  = lit ? ~(N'(1) << slot) : {N{1'b1}};
    exp_seg = lit ? hex_tbl[nib] : 7'h7F;
`ifdef SSEG_DP_EN
    exp_dp  = lit ? ~dp_in[slot] : 1'b1;
`else
    exp_dp  = 1'b1;
`endif
    #1;
    check_eq("an", 32'(an), 32'(exp_an));
    check_eq("seg", 32'(seg), 32'(exp_seg));
`ifdef SSEG_DP_EN
    check_eq("dp_n", 32'(dp_n), 32'(exp_dp));
`else
    if (exp_dp !== 1'b1) $display("unexpected dp state");
`endif
  endtask

  initial begin
    reset    = 1'b1;
    digits   = 16'h1234;
    digit_en = 4'hF;
`ifdef SSEG_DP_EN
    dp_in    = 4'b0010;
`endif
    repeat (3) step();
    reset = 1'b0;

    // Free-running scan with all digits enabled: two full periods.
    repeat (2 * N * R) step();

    // Alternate digits blanked.
    digit_en = 4'b0101;
    repeat (N * R) step();

    // Reset pulse while digit 2 is driven, then resume.
    digit_en = 4'hF;
    while (!(n_edges % (N * R) == 2 * R + 4)) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (R + 2) step();

    // Mid-slot change of digit 0 from 4 to F.
    while (!(n_edges % (N * R) == N * R - 4)) step();
    digits[3:0] = 4'hF;
    repeat (R) step();

    // Randomized inputs with occasional resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
`ifdef SSEG_DP_EN
      if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom);
`endif
      reset = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
